imem_dmem_arbiter: RTL
======================

// Module: imem_dmem_arbiter
// PURPOSE
//  Shares one byte-addressed 32-bit program/data memory port between the fetch
//  stage (read-only) and the LSU (read/write). Sits between core and memory;
//  one transaction outstanding, round-robin arbitration, responses routed back
//  to the owning requester.
// PARAMETERS
//  ADDR_W   16  byte-address width of both requesters and the memory port
//  DATA_W   32  data width; must be 32 (4 byte lanes)
// PORTS
//  i_clk          in   1       clock, rising edge
//  i_reset        in   1       asynchronous reset, active-high
//  i_if_req       in   1       fetch request (held until granted)
//  i_if_addr      in   ADDR_W  fetch byte address
//  o_if_gnt       out  1       fetch request accepted this cycle
//  o_if_rvalid    out  1       fetch read data valid (1-cycle pulse)
//  o_if_rdata     out  DATA_W  fetch read data
//  i_ls_req       in   1       LSU request (held until granted)
//  i_ls_we        in   1       1 = write, 0 = read
//  i_ls_addr      in   ADDR_W  LSU byte address
//  i_ls_wdata     in   DATA_W  LSU write data
//  i_ls_be        in   4       LSU byte enables (write only)
//  o_ls_gnt       out  1       LSU request accepted this cycle
//  o_ls_rvalid    out  1       LSU response (read data or write ack), 1-cycle
//  o_ls_rdata     out  DATA_W  LSU read data (0 on write ack)
//  o_mem_req      out  1       memory command valid (1-cycle pulse)
//  o_mem_we/addr/wdata/be out  1/ADDR_W/DATA_W/4  registered copy of winner
//  i_mem_rvalid   in   1       memory completion, any latency >= 1 cycle
//  i_mem_rdata    in   DATA_W  memory read data, valid with i_mem_rvalid
// BEHAVIOUR
//  - Reset (async, i_reset=1): state IDLE, rr pointer = fetch-preferred, all
//    o_* outputs 0. Reset mid-transaction drops it; a later i_mem_rvalid
//    arriving in IDLE is ignored (no rvalid to any requester).
//  - FSM IDLE -> WAIT when any request present: gnt asserted combinationally
//    to winner in that cycle; mem command registered, o_mem_req high the next
//    cycle for exactly one cycle. Requests are ignored (gnt=0) in WAIT.
//  - WAIT -> IDLE on i_mem_rvalid: owner's rvalid pulses that same cycle with
//    rdata = i_mem_rdata (reads) or 0 (writes); other requester's rvalid = 0.
//    Earliest next grant is the cycle after. Min request-to-data: 2 cycles.
//  - Arbitration: single requester wins immediately. Both in same cycle: winner
//    is the one NOT granted last (rr pointer flips on every grant). First
//    contention after reset goes to fetch.
//  - Addresses pass unaltered (byte address, no alignment check, no wrap
//    logic); i_ls_be forced to 4'hF on reads, fetch be always 4'hF.
//  - gnt and rvalid never both high for the same requester in one cycle.
// CONFIGURATION
//  ARB_LSU_PRIORITY_EN: when defined, fixed priority - LSU always wins
//  contention, rr pointer removed. Undefined: round-robin as above.
// STRUCTURE
//  - Shared package mem_arb_pkg: typedef arb_state_e {ARB_IDLE, ARB_WAIT};
//    typedef arb_owner_e {OWN_IF, OWN_LS}; localparam BE_ALL = 4'hF.
//  - Sub-module rr_arb2 (2-input round-robin grant, pointer register inside);
//    bypassed under ARB_LSU_PRIORITY_EN.
// TESTING
//  1. Reset: assert i_reset mid-WAIT -> all outputs 0 same cycle; late
//     i_mem_rvalid=1 rdata=32'hDEAD_BEEF -> no rvalid on either side.
//  2. Fetch only: i_if_addr=16'h0004 -> o_if_gnt cycle 0, o_mem_req cycle 1
//     addr=0004 we=0 be=F; mem rvalid rdata=32'h0010_0093 -> o_if_rdata same.
//  3. Contention from reset: both req -> fetch granted; hold both -> LSU next,
//     then fetch; grants strictly alternate IF,LS,IF,LS over 8 transactions.
//  4. LSU write addr=16'h0100 wdata=32'h1234_5678 be=4'b0011 -> mem sees exact
//     values we=1; ack -> o_ls_rvalid=1, o_ls_rdata=0, o_if_rvalid=0.
//  5. Requests during WAIT (latency 5): no gnt until cycle after i_mem_rvalid;
//     held request then granted without loss.
//  6. With ARB_LSU_PRIORITY_EN: both req continuously -> LSU granted every
//     transaction, fetch only when i_ls_req=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/LSU memory-port arbiter.
package mem_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_WAIT = 1'b1
    } arb_state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    localparam logic [3:0] BE_ALL = 4'hF;

    // Byte enables sent to memory for an LSU command: reads always fetch the full word.
    function automatic logic [3:0] ls_mem_be(input logic we, input logic [3:0] be);
        return we ? be : BE_ALL;
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the core requesters (fetch, LSU), the arbiter and the memory port.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              i_if_req;
    logic [ADDR_W-1:0] i_if_addr;
    logic              o_if_gnt;
    logic              o_if_rvalid;
    logic [DATA_W-1:0] o_if_rdata;

    logic              i_ls_req;
    logic              i_ls_we;
    logic [ADDR_W-1:0] i_ls_addr;
    logic [DATA_W-1:0] i_ls_wdata;
    logic [3:0]        i_ls_be;
    logic              o_ls_gnt;
    logic              o_ls_rvalid;
    logic [DATA_W-1:0] o_ls_rdata;

    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [DATA_W-1:0] o_mem_wdata;
    logic [3:0]        o_mem_be;
    logic              i_mem_rvalid;
    logic [DATA_W-1:0] i_mem_rdata;

    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_be,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        input  i_mem_rvalid, i_mem_rdata
    );

    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_we, i_ls_addr, i_ls_wdata, i_ls_be,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be,
        output i_mem_rvalid, i_mem_rdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin grant; under contention the requester not granted last wins.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    // 0 = fetch (bit 0) preferred, 1 = LSU (bit 1) preferred
    logic prefer_ls;

    always_comb begin
        gnt = 2'b00;
        if (req[0] && req[1]) begin
            gnt = prefer_ls ? 2'b10 : 2'b01;
        end else begin
            gnt = req;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            prefer_ls <= 1'b0;
        end else if (advance && (gnt != 2'b00)) begin
            prefer_ls <= gnt[0];
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one memory port between fetch and LSU, one transaction in flight.
// Define ARB_LSU_PRIORITY_EN for fixed LSU priority instead of round-robin.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARB_IDLE | no transaction outstanding; any request is granted now
//   ARB_WAIT | command issued, waiting for i_mem_rvalid; requests held off
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    imem_dmem_arbiter_if.slave    bus
);

    arb_state_e        state;
    arb_state_e        state_nxt;
    arb_owner_e        owner;
    logic [1:0]        req;
    logic [1:0]        win;
    logic              if_gnt;
    logic              ls_gnt;
    logic              if_rvalid;
    logic              ls_rvalid;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [3:0]        mem_be;

    assign req = {bus.i_ls_req, bus.i_if_req};

`ifdef ARB_LSU_PRIORITY_EN
    always_comb begin
        win = 2'b00;
        if (req[1]) begin
            win = 2'b10;
        end else if (req[0]) begin
            win = 2'b01;
        end
    end
`else
    logic advance;

    assign advance = (state == ARB_IDLE) && !i_reset;

    rr_arb2 u_rr_arb2 (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .req     (req),
        .advance (advance),
        .gnt     (win)
    );
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Grants are combinational, so they are gated while reset is held.
    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        case (state)
            ARB_IDLE: begin
                if ((req != 2'b00) && !i_reset) begin
                    state_nxt = ARB_WAIT;
                    if_gnt    = win[0];
                    ls_gnt    = win[1];
                end
            end
            ARB_WAIT: begin
                if (bus.i_mem_rvalid) begin
                    state_nxt = ARB_IDLE;
                    if_rvalid = (owner == OWN_IF);
                    ls_rvalid = (owner == OWN_LS);
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= 4'h0;
            owner     <= OWN_IF;
        end else begin
            mem_req <= if_gnt || ls_gnt;
            if (ls_gnt) begin
                mem_we    <= bus.i_ls_we;
                mem_addr  <= bus.i_ls_addr;
                mem_wdata <= bus.i_ls_wdata;
                mem_be    <= ls_mem_be(bus.i_ls_we, bus.i_ls_be);
                owner     <= OWN_LS;
            end else if (if_gnt) begin
                mem_we    <= 1'b0;
                mem_addr  <= bus.i_if_addr;
                mem_wdata <= '0;
                mem_be    <= BE_ALL;
                owner     <= OWN_IF;
            end
        end
    end

    assign bus.o_if_gnt    = if_gnt;
    assign bus.o_ls_gnt    = ls_gnt;
    assign bus.o_if_rvalid = if_rvalid;
    assign bus.o_ls_rvalid = ls_rvalid;
    // mem_we still holds the owner's direction while the response is returned
    assign bus.o_if_rdata  = if_rvalid ? bus.i_mem_rdata : '0;
    assign bus.o_ls_rdata  = (ls_rvalid && !mem_we) ? bus.i_mem_rdata : '0;

    assign bus.o_mem_req   = mem_req;
    assign bus.o_mem_we    = mem_we;
    assign bus.o_mem_addr  = mem_addr;
    assign bus.o_mem_wdata = mem_wdata;
    assign bus.o_mem_be    = mem_be;

endmodule
